param_stream_loader: RTL and testbench

Writable counterpart to the per-parameter ROM sources: accepts a parameter tensor (for example a query bias) as a valid/ready beat stream from the host/DMA side and writes it into an on-chip RAM. A 2-cycle, ROM-compatible read port then serves the stored words, so downstream parameter sources can read from loaded RAM instead of a `$readmemh` image. A `load_done` flag marks the point at which the full tensor is resident.

---
 rtl/param_loader_pkg.sv | 12 +
 rtl/param_loader_ram.sv | 48 ++++
 rtl/param_stream_loader.sv | 135 +++++++++++++
 tb/tb_param_stream_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_loader_pkg.sv
// Shared types for the parameter stream loader: FSM state encoding and checksum width.
package param_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } param_loader_state_t;

    localparam int PARAM_LOADER_CSUM_W = 32;

endpackage

// File: rtl/param_loader_ram.sv
// Simple dual-port parameter RAM: one write port, one 2-stage registered read port
// (both read stages gated by ce, read-first on a same-cycle collision).
module param_loader_ram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 32,
    parameter int AWIDTH = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              ce,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  q
);

    localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_stage_q;
    logic [WIDTH-1:0] rd_out_q;
    logic [MAW-1:0]   waddr_w;
    logic [MAW-1:0]   raddr_w;

    // Addresses beyond DEPTH alias onto a real word; their read data is don't-care.
    assign waddr_w = waddr[MAW-1:0];
    assign raddr_w = raddr[MAW-1:0];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr_w] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_stage_q <= '0;
            rd_out_q   <= '0;
        end else if (ce) begin
            rd_stage_q <= mem[raddr_w];
            rd_out_q   <= rd_stage_q;
        end
    end

    assign q = rd_out_q;

endmodule

// File: rtl/param_stream_loader.sv
// Loads a parameter tensor from a valid/ready beat stream into RAM and serves it on a
// 2-cycle ROM-style read port. Define PARAM_LOADER_CHECKSUM_EN to add the checksum output.
module param_stream_loader
    import param_loader_pkg::*;
#(
    parameter int PRECISION_0       = 16,
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int PARALLELISM_DIM_0 = 1,
    parameter int DEPTH             = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
    parameter int AWIDTH            = $clog2(DEPTH) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load_start,
    input  logic [PRECISION_0-1:0]               data_in [PARALLELISM_DIM_0],
    input  logic                                 data_in_valid,
    output logic                                 data_in_ready,
    input  logic [AWIDTH-1:0]                    rd_addr,
    input  logic                                 rd_ce,
    output logic [PRECISION_0*PARALLELISM_DIM_0-1:0] rd_q,
    output logic                                 load_done,
    output logic [AWIDTH-1:0]                    beat_count
`ifdef PARAM_LOADER_CHECKSUM_EN
    ,
    output logic [PARAM_LOADER_CSUM_W-1:0]       checksum
`endif
);

    localparam int WIDTH = PRECISION_0 * PARALLELISM_DIM_0;
    localparam logic [AWIDTH-1:0] LAST_BEAT = AWIDTH'(DEPTH - 1);

    param_loader_state_t state_q, state_d;
    logic [AWIDTH-1:0]   beat_count_q, beat_count_d;
    logic [WIDTH-1:0]    wdata;
    logic                accept;
    logic                ram_we;

    generate
        for (genvar gi = 0; gi < PARALLELISM_DIM_0; gi++) begin : g_pack
            assign wdata[PRECISION_0*gi +: PRECISION_0] = data_in[gi];
        end
    endgenerate

    assign accept = data_in_valid && (state_q == LOAD);
    // A restart in the same cycle as a beat drops that beat.
    assign ram_we = accept && !load_start;

    always_comb begin
        state_d      = state_q;
        beat_count_d = beat_count_q;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d      = LOAD;
                    beat_count_d = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    beat_count_d = '0;
                end else if (accept) begin
                    beat_count_d = beat_count_q + AWIDTH'(1);
                    if (beat_count_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (load_start) begin
                    state_d      = LOAD;
                    beat_count_d = '0;
                end
            end
            default: begin
                state_d      = IDLE;
                beat_count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign data_in_ready = (state_q == LOAD);
    assign load_done     = (state_q == DONE);
    assign beat_count    = beat_count_q;

`ifdef PARAM_LOADER_CHECKSUM_EN
    logic [PARAM_LOADER_CSUM_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (load_start) begin
            checksum_d = '0;
        end else if (accept) begin
            for (int i = 0; i < PARALLELISM_DIM_0; i++) begin
                checksum_d = checksum_d + PARAM_LOADER_CSUM_W'(data_in[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    param_loader_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (beat_count_q),
        .wdata (wdata),
        .ce    (rd_ce),
        .raddr (rd_addr),
        .q     (rd_q)
    );

endmodule

// File: tb/tb_param_stream_loader.sv
// Directed bench for param_stream_loader: a scalar-beat instance (DEPTH 32) and a
// 4-wide instance (DEPTH 8); read results are checked through an expected-value queue.
module tb_param_stream_loader;

    logic        clk = 1'b0;
    logic        rst;

    // Scalar instance
    logic        load_start;
    logic [15:0] data_in [1];
    logic        data_in_valid;
    logic        data_in_ready;
    logic [5:0]  rd_addr;
    logic        rd_ce;
    logic [15:0] rd_q;
    logic        load_done;
    logic [5:0]  beat_count;

    // 4-wide instance
    logic        load_start4;
    logic [15:0] data_in4 [4];
    logic        data_in_valid4;
    logic        data_in_ready4;
    logic [3:0]  rd_addr4;
    logic        rd_ce4;
    logic [63:0] rd_q4;
    logic        load_done4;
    logic [3:0]  beat_count4;

`ifdef PARAM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
    logic [31:0] checksum4;
`endif

    always #5 clk = ~clk;

    param_stream_loader #(
        .PRECISION_0       (16),
        .TENSOR_SIZE_DIM_0 (32),
        .PARALLELISM_DIM_0 (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .rd_addr       (rd_addr),
        .rd_ce         (rd_ce),
        .rd_q          (rd_q),
        .load_done     (load_done),
        .beat_count    (beat_count)
`ifdef PARAM_LOADER_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    param_stream_loader #(
        .PRECISION_0       (16),
        .TENSOR_SIZE_DIM_0 (32),
        .PARALLELISM_DIM_0 (4)
    ) dut4 (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start4),
        .data_in       (data_in4),
        .data_in_valid (data_in_valid4),
        .data_in_ready (data_in_ready4),
        .rd_addr       (rd_addr4),
        .rd_ce         (rd_ce4),
        .rd_q          (rd_q4),
        .load_done     (load_done4),
        .beat_count    (beat_count4)
`ifdef PARAM_LOADER_CHECKSUM_EN
        ,
        .checksum      (checksum4)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_mem [32];
    logic [15:0] exp_q [$];
    logic [15:0] last_exp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue reads lo..hi back to back with rd_ce held high; each result is popped
    // from the queue as it emerges two edges after its address was sampled.
    task automatic read_range(input int lo, input int hi, input string tag);
        int n;
        logic [15:0] e;
        n = hi - lo + 1;
        for (int i = 0; i <= n; i++) begin
            rd_ce = 1'b1;
            if (i < n) begin
                rd_addr = 6'(lo + i);
                exp_q.push_back(exp_mem[lo + i]);
            end
            tick();
            if (i >= 1) begin
                e = exp_q.pop_front();
                last_exp = e;
                chk($sformatf("%s_rd%0d", tag, lo + i - 1), 64'(rd_q), 64'(e));
            end
        end
        rd_ce = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        int          idx;
        int          cyc;
        logic [31:0] sum;

        rst            = 1'b1;
        load_start     = 1'b0;
        data_in[0]     = '0;
        data_in_valid  = 1'b0;
        rd_addr        = '0;
        rd_ce          = 1'b0;
        load_start4    = 1'b0;
        data_in4       = '{default: '0};
        data_in_valid4 = 1'b0;
        rd_addr4       = '0;
        rd_ce4         = 1'b0;
        last_exp       = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset / idle state
        chk("rst_ready", 64'(data_in_ready), 64'(0));
        chk("rst_done", 64'(load_done), 64'(0));
        chk("rst_bc", 64'(beat_count), 64'(0));
        chk("rst_rdq", 64'(rd_q), 64'(0));
`ifdef PARAM_LOADER_CHECKSUM_EN
        chk("rst_csum", 64'(checksum), 64'(0));
`endif

        // Back-to-back load of 1..32
        pulse_start();
        chk("ld1_ready", 64'(data_in_ready), 64'(1));
        chk("ld1_bc0", 64'(beat_count), 64'(0));
        for (int i = 0; i < 32; i++) begin
            data_in_valid = 1'b1;
            data_in[0]    = 16'(i + 1);
            exp_mem[i]    = 16'(i + 1);
            tick();
            if (i == 30) chk("ld1_done_early", 64'(load_done), 64'(0));
        end
        data_in_valid = 1'b0;
        chk("ld1_done", 64'(load_done), 64'(1));
        chk("ld1_ready_off", 64'(data_in_ready), 64'(0));
        chk("ld1_bc", 64'(beat_count), 64'(32));
`ifdef PARAM_LOADER_CHECKSUM_EN
        chk("ld1_csum", 64'(checksum), 64'(528));
`endif
        read_range(0, 31, "ld1");

        // rd_ce low freezes the read pipeline
        rd_addr = 6'd3;
        tick();
        tick();
        chk("freeze_rdq", 64'(rd_q), 64'(last_exp));

        // Same load with randomly gated valid
        pulse_start();
        chk("ld2_done_clr", 64'(load_done), 64'(0));
        idx = 0;
        cyc = 0;
        while (!load_done && cyc < 1000) begin
            data_in_valid = 1'($urandom_range(0, 1));
            data_in[0]    = 16'(idx + 1);
            if (data_in_valid && data_in_ready) idx++;
            tick();
            cyc++;
        end
        data_in_valid = 1'b0;
        chk("ld2_finished", 64'(load_done), 64'(1));
        chk("ld2_beats", 64'(idx), 64'(32));
        chk("ld2_bc", 64'(beat_count), 64'(32));
`ifdef PARAM_LOADER_CHECKSUM_EN
        chk("ld2_csum", 64'(checksum), 64'(528));
`endif
        read_range(0, 31, "ld2");

        // Abort after 10 beats; restart drops a concurrent beat
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            data_in_valid = 1'b1;
            data_in[0]    = 16'h5555;
            tick();
        end
        chk("ab_bc10", 64'(beat_count), 64'(10));
        load_start = 1'b1;
        data_in[0] = 16'h7777;
        tick();
        load_start = 1'b0;
        chk("ab_bc0", 64'(beat_count), 64'(0));
        chk("ab_ready", 64'(data_in_ready), 64'(1));
        for (int i = 0; i < 32; i++) begin
            data_in[0] = 16'hAAAA;
            exp_mem[i] = 16'hAAAA;
            tick();
        end
        data_in_valid = 1'b0;
        chk("ab_done", 64'(load_done), 64'(1));
`ifdef PARAM_LOADER_CHECKSUM_EN
        chk("ab_csum", 64'(checksum), 64'(32 * 32'hAAAA));
`endif
        read_range(0, 31, "ab");

        // Partial load then abort: only rewritten words change
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            data_in_valid = 1'b1;
            data_in[0]    = 16'(16'h0101 + i);
            exp_mem[i]    = 16'(16'h0101 + i);
            tick();
        end
        data_in_valid = 1'b0;
        pulse_start();
        read_range(0, 5, "part");

        // Collision: write word 5 while reading address 5 in the same cycle
        for (int i = 0; i < 5; i++) begin
            data_in_valid = 1'b1;
            data_in[0]    = 16'(16'h1000 + i);
            exp_mem[i]    = 16'(16'h1000 + i);
            tick();
        end
        data_in[0] = 16'h1234;
        rd_addr    = 6'd5;
        rd_ce      = 1'b1;
        exp_q.push_back(exp_mem[5]);
        tick();
        data_in_valid = 1'b0;
        exp_mem[5]    = 16'h1234;
        exp_q.push_back(exp_mem[5]);
        tick();
        chk("coll_same_cycle", 64'(rd_q), 64'(exp_q.pop_front()));
        tick();
        chk("coll_next_cycle", 64'(rd_q), 64'(exp_q.pop_front()));
        rd_ce = 1'b0;
        chk("coll_bc", 64'(beat_count), 64'(6));

        // 4-wide instance: element 0 at the low bits
        load_start4 = 1'b1;
        tick();
        load_start4 = 1'b0;
        chk("p4_ready", 64'(data_in_ready4), 64'(1));
        data_in4       = '{16'h1, 16'h2, 16'h3, 16'h4};
        data_in_valid4 = 1'b1;
        tick();
        data_in_valid4 = 1'b0;
        chk("p4_bc", 64'(beat_count4), 64'(1));
`ifdef PARAM_LOADER_CHECKSUM_EN
        chk("p4_csum", 64'(checksum4), 64'(10));
`endif
        rd_addr4 = 4'd0;
        rd_ce4   = 1'b1;
        tick();
        tick();
        rd_ce4 = 1'b0;
        chk("p4_lo", 64'(rd_q4[15:0]), 64'(16'h1));
        chk("p4_hi", 64'(rd_q4[63:48]), 64'(16'h4));
        chk("p4_word", rd_q4, 64'h0004_0003_0002_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
